// File: rtl/spike_window_classifier.sv
// spike_window_classifier
//   Counts output spikes per neuron over a window of enabled samples, then
//   scans the counts one neuron per cycle to pick a winner. The result is held
//   behind a valid/ready handshake.
//
//   Optional build macro: SPIKE_CLASS_CONTINUOUS_EN
//     defined   -> the REPORT handshake restarts the next window with the
//                  latched window_len (COUNT, or COMPARE if it is 0); no start
//                  is needed after the first window.
//     undefined -> the handshake returns to IDLE.
//
// Ports:
//   clk, reset (sync, active low)
//   enable        sample qualifier in COUNT
//   start         begins a window (IDLE only)
//   window_len    enabled samples per window, latched on start
//   spikes_in     N-bit spike vector
//   result_ready  consumer handshake
//   busy          state != IDLE
//   result_valid  REPORT state
//   winner_idx, tie, no_spike   class decision
//   counts_out    per-neuron counts, lane i at [i*CW +: CW]

// Per-lane saturating spike counter.
module spike_lane_counter #(
  parameter int CW = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          smp,
  input  logic          spike,
  output logic [CW-1:0] count
);
  always_ff @(posedge clk) begin
    if (!reset)                             count <= '0;
    else if (clr)                           count <= '0;
    else if (smp && spike && (count != '1)) count <= count + 1'b1;
  end
endmodule

module spike_window_classifier #(
  parameter int N    = 2,
  parameter int CW   = 6,
  parameter int WLW  = 8,
  parameter int IDXW = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic            start,
  input  logic [WLW-1:0]  window_len,
  input  logic [N-1:0]    spikes_in,
  input  logic            result_ready,
  output logic            busy,
  output logic            result_valid,
  output logic [IDXW-1:0] winner_idx,
  output logic            tie,
  output logic            no_spike,
  output logic [N*CW-1:0] counts_out
);
  typedef enum logic [1:0] {IDLE, COUNT, COMPARE, REPORT} state_t;

  state_t               state, state_nxt;
  logic [N-1:0][CW-1:0] counts;
  logic [WLW-1:0]       wlen, sample_cnt, sample_nxt;
  logic [IDXW-1:0]      scan_idx, idx_nxt;
  logic [CW-1:0]        best, best_nxt, cur;
  logic                 tie_nxt;
  logic                 start_ok, hs, smp, last_smp, last_scan, clr, restart;

  assign start_ok   = (state == IDLE) && start;
  assign hs         = (state == REPORT) && result_ready;
  assign smp        = (state == COUNT) && enable;
  assign sample_nxt = sample_cnt + 1'b1;
  assign last_smp   = smp && (sample_nxt == wlen);
  assign last_scan  = (state == COMPARE) && (scan_idx == IDXW'(N-1));

`ifdef SPIKE_CLASS_CONTINUOUS_EN
  assign restart = hs;
`else
  assign restart = 1'b0;
`endif

  // Counts restart from zero on every new window.
  assign clr = start_ok || restart;

  for (genvar i = 0; i < N; i++) begin : g_lane
    spike_lane_counter #(.CW(CW)) u_lane (
      .clk   (clk),
      .reset (reset),
      .clr   (clr),
      .smp   (smp),
      .spike (spikes_in[i]),
      .count (counts[i])
    );
  end

  assign counts_out   = counts;
  assign busy         = (state != IDLE);
  assign result_valid = (state == REPORT);

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (window_len != '0) ? COUNT : COMPARE;
      COUNT:   if (last_smp) state_nxt = COMPARE;
      COMPARE: if (last_scan) state_nxt = REPORT;
      REPORT:  if (result_ready) begin
`ifdef SPIKE_CLASS_CONTINUOUS_EN
        state_nxt = (wlen != '0) ? COUNT : COMPARE;
`else
        state_nxt = IDLE;
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  // One scan step: index 0 seeds the best; strict > replaces it so the lowest
  // index keeps ties. An all-zero window naturally ends at idx 0 with tie set.
  assign cur = counts[scan_idx];
  always_comb begin
    best_nxt = best;
    idx_nxt  = winner_idx;
    tie_nxt  = tie;
    if (scan_idx == '0) begin
      best_nxt = cur;
      idx_nxt  = '0;
      tie_nxt  = 1'b0;
    end else if (cur > best) begin
      best_nxt = cur;
      idx_nxt  = scan_idx;
      tie_nxt  = 1'b0;
    end else if (cur == best) begin
      tie_nxt  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wlen       <= '0;
      sample_cnt <= '0;
      scan_idx   <= '0;
      best       <= '0;
      winner_idx <= '0;
      tie        <= 1'b0;
      no_spike   <= 1'b0;
    end else begin
      if (start_ok) begin
        wlen       <= window_len;
        winner_idx <= '0;
        tie        <= 1'b0;
        no_spike   <= 1'b0;
      end
      if (clr) begin
        sample_cnt <= '0;
        scan_idx   <= '0;
      end else if (smp) begin
        sample_cnt <= sample_nxt;
      end
      if (state == COMPARE) begin
        best       <= best_nxt;
        winner_idx <= idx_nxt;
        tie        <= tie_nxt;
        scan_idx   <= last_scan ? '0 : scan_idx + 1'b1;
        if (last_scan) no_spike <= (best_nxt == '0);
      end
    end
  end
endmodule

// File: tb/tb_spike_window_classifier.sv
module tb_spike_window_classifier;
  logic        clk = 1'b0;
  logic        reset, enable, start, result_ready;
  logic [7:0]  window_len;
  logic [1:0]  spikes_in;
  logic        busy, result_valid, winner_idx, tie, no_spike;
  logic [11:0] counts_out;
  int checks = 0;
  int errors = 0;

  spike_window_classifier #(.N(2), .CW(6), .WLW(8), .IDXW(1)) dut (
    .clk(clk), .reset(reset), .enable(enable), .start(start),
    .window_len(window_len), .spikes_in(spikes_in),
    .result_ready(result_ready), .busy(busy), .result_valid(result_valid),
    .winner_idx(winner_idx), .tie(tie), .no_spike(no_spike),
    .counts_out(counts_out)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_result(input string tag, input logic [11:0] cnt,
                            input logic w, input logic t, input logic ns);
    chk({tag, ".valid"}, {31'd0, result_valid}, 32'd1);
    chk({tag, ".counts"}, {20'd0, counts_out}, {20'd0, cnt});
    chk({tag, ".winner"}, {31'd0, winner_idx}, {31'd0, w});
    chk({tag, ".tie"}, {31'd0, tie}, {31'd0, t});
    chk({tag, ".no_spike"}, {31'd0, no_spike}, {31'd0, ns});
  endtask

  task automatic handshake(input string tag);
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    chk({tag, ".hs_valid"}, {31'd0, result_valid}, 32'd0);
    chk({tag, ".hs_busy"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic go(input logic [7:0] wl);
    window_len = wl;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; start = 1'b0; result_ready = 1'b0;
    window_len = 8'd0; spikes_in = 2'b00;
    tick(2);
    chk("rst.busy", {31'd0, busy}, 32'd0);
    chk("rst.valid", {31'd0, result_valid}, 32'd0);
    chk("rst.counts", {20'd0, counts_out}, 32'd0);
    chk("rst.flags", {29'd0, winner_idx, tie, no_spike}, 32'd0);
    reset = 1'b1;

    // Window of 4 with a clear winner on lane 1.
    enable = 1'b1;
    go(8'd4);
    chk("t1.busy", {31'd0, busy}, 32'd1);
    spikes_in = 2'b10; tick();
    spikes_in = 2'b10; tick();
    spikes_in = 2'b11; tick();
    spikes_in = 2'b10; tick();
    spikes_in = 2'b00;
    chk("t1.cmp0", {31'd0, result_valid}, 32'd0);
    tick();
    chk("t1.cmp1", {31'd0, result_valid}, 32'd0);
    tick();
    chk_result("t1", {6'd4, 6'd1}, 1'b1, 1'b0, 1'b0);
    handshake("t1");

    // Gated samples: only the three enabled cycles count; equal counts tie.
    spikes_in = 2'b11;
    go(8'd3);
    enable = 1'b1; tick();
    enable = 1'b0; tick();
    chk("t2.frozen", {20'd0, counts_out}, {20'd0, 6'd1, 6'd1});
    enable = 1'b1; tick();
    enable = 1'b0; tick();
    enable = 1'b1; tick();
    enable = 1'b0; spikes_in = 2'b00;
    tick(2);
    chk_result("t2", {6'd3, 6'd3}, 1'b0, 1'b1, 1'b0);
    handshake("t2");

    // Silent window, then a zero-length window.
    enable = 1'b1;
    go(8'd5);
    tick(5);
    tick(2);
    chk_result("t3", 12'd0, 1'b0, 1'b1, 1'b1);
    handshake("t3");
    go(8'd0);
    chk("t3z.cmp0", {31'd0, result_valid}, 32'd0);
    tick();
    chk("t3z.cmp1", {31'd0, result_valid}, 32'd0);
    tick();
    chk_result("t3z", 12'd0, 1'b0, 1'b1, 1'b1);
    handshake("t3z");

    // Saturation at 63 over a 100-sample window.
    spikes_in = 2'b01;
    go(8'd100);
    tick(100);
    spikes_in = 2'b00;
    tick(2);
    chk_result("t4", {6'd0, 6'd63}, 1'b0, 1'b0, 1'b0);

    // Backpressure with a stray start while holding the result.
    for (int i = 0; i < 5; i++) begin
      start = (i == 2);
      window_len = 8'd7;
      tick();
    end
    start = 1'b0;
    chk_result("t5", {6'd0, 6'd63}, 1'b0, 1'b0, 1'b0);
    chk("t5.busy", {31'd0, busy}, 32'd1);
    handshake("t5");
    chk("t5.hold", {20'd0, counts_out}, {20'd0, 6'd0, 6'd63});

    // Reset mid-window, then a clean window.
    spikes_in = 2'b11;
    go(8'd4);
    tick(2);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("t6.busy", {31'd0, busy}, 32'd0);
    chk("t6.counts", {20'd0, counts_out}, 32'd0);
    chk("t6.valid", {31'd0, result_valid}, 32'd0);
    spikes_in = 2'b01;
    go(8'd2);
    tick(2);
    spikes_in = 2'b00;
    tick(2);
    chk_result("t6", {6'd0, 6'd2}, 1'b0, 1'b0, 1'b0);
    handshake("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
